// File: rtl/wishbone_copy_master.sv
// -----------------------------------------------------------------------------
// wishbone_copy_master
//
// Wishbone classic-cycle initiator that copies a block of words from a source
// address range to a destination address range. Each word is read into a
// holding register and then written back out. Every acknowledged access is
// followed by one idle cycle with the strobe low. That idle cycle lets a
// responder with a registered ack see the strobe drop before the next request
// begins, so it never acks the same access twice.
//
// Optional feature (macro WISHBONE_COPY_TIMEOUT_EN):
//   Defined   - a bus request that sees no ack_i within TIMEOUT_CYCLES cycles
//               is abandoned. err_o is set and the copy ends through DONE.
//   Undefined - the master waits indefinitely for ack_i and err_o is tied 0.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous active-low reset
//   start_i    copy request, sampled only when idle
//   src_adr_i  first source word address (latched on accepted start)
//   dst_adr_i  first destination word address (latched on accepted start)
//   len_i      number of words to copy (latched on accepted start)
//   busy_o     copy in progress
//   done_o     one-cycle completion pulse (normal, zero-length or error)
//   err_o      sticky timeout flag, cleared by the next accepted start
//   adr_o, dat_o, dat_i, we_o, sel_o, stb_o, cyc_o, ack_i, cti_o
//              Wishbone classic initiator signals
// -----------------------------------------------------------------------------
module wishbone_copy_master #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_BYTES     = 1,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [ADDRESS_WIDTH-1:0] src_adr_i,
  input  logic [ADDRESS_WIDTH-1:0] dst_adr_i,
  input  logic [LEN_WIDTH-1:0]     len_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [ADDRESS_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0]    dat_o,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic                     we_o,
  output logic [DATA_BYTES-1:0]    sel_o,
  output logic                     stb_o,
  output logic                     cyc_o,
  input  logic                     ack_i,
  output logic [2:0]               cti_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_GAP = 3'd2,
    WR_REQ = 3'd3,
    WR_GAP = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                   state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] src_reg, src_next;
  logic [ADDRESS_WIDTH-1:0] dst_reg, dst_next;
  logic [ADDRESS_WIDTH-1:0] adr_reg, adr_next;
  logic [LEN_WIDTH-1:0]     len_reg, len_next;
  logic [LEN_WIDTH-1:0]     count_reg, count_next;
  logic [DATA_WIDTH-1:0]    hold_reg, hold_next;
  logic [DATA_WIDTH-1:0]    dat_reg, dat_next;
  logic                     stb_reg, stb_next;
  logic                     we_reg, we_next;
  logic                     busy_reg, busy_next;
  logic                     done_reg, done_next;

`ifdef WISHBONE_COPY_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_reg, tmo_next;
  logic          err_reg, err_next;
  logic          tmo_hit;
  logic          abort;
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      adr_reg   <= '0;
      len_reg   <= '0;
      count_reg <= '0;
      hold_reg  <= '0;
      dat_reg   <= '0;
      stb_reg   <= 1'b0;
      we_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef WISHBONE_COPY_TIMEOUT_EN
      tmo_reg   <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      adr_reg   <= adr_next;
      len_reg   <= len_next;
      count_reg <= count_next;
      hold_reg  <= hold_next;
      dat_reg   <= dat_next;
      stb_reg   <= stb_next;
      we_reg    <= we_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
`ifdef WISHBONE_COPY_TIMEOUT_EN
      tmo_reg   <= tmo_next;
      err_reg   <= err_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. The bus outputs are computed one cycle
  // ahead so that every port comes straight from a flop.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    adr_next   = adr_reg;
    len_next   = len_reg;
    count_next = count_reg;
    hold_next  = hold_reg;
    dat_next   = dat_reg;
    stb_next   = stb_reg;
    we_next    = we_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
`ifdef WISHBONE_COPY_TIMEOUT_EN
    err_next   = err_reg;
    // The counter restarts from zero whenever it is not explicitly advanced.
    // This resets it on entry to each request state.
    tmo_next   = '0;
    tmo_hit    = (tmo_reg == TMO_LAST);
    abort      = 1'b0;
`endif

    unique case (state_reg)
      IDLE: begin
        if (start_i) begin
          src_next   = src_adr_i;
          dst_next   = dst_adr_i;
          len_next   = len_i;
          count_next = '0;
`ifdef WISHBONE_COPY_TIMEOUT_EN
          err_next   = 1'b0;
`endif
          if (len_i == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = RD_REQ;
            busy_next  = 1'b1;
            stb_next   = 1'b1;
            we_next    = 1'b0;
            adr_next   = src_adr_i;
          end
        end
      end

      RD_REQ: begin
        if (ack_i) begin
          hold_next  = dat_i;
          stb_next   = 1'b0;
          state_next = RD_GAP;
        end
`ifdef WISHBONE_COPY_TIMEOUT_EN
        else if (tmo_hit) begin
          abort = 1'b1;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
`endif
      end

      // A stale registered ack may still be high here. It is ignored because
      // this state always advances.
      RD_GAP: begin
        state_next = WR_REQ;
        stb_next   = 1'b1;
        we_next    = 1'b1;
        adr_next   = dst_reg + ADDRESS_WIDTH'(count_reg);
        dat_next   = hold_reg;
      end

      WR_REQ: begin
        if (ack_i) begin
          stb_next   = 1'b0;
          we_next    = 1'b0;
          count_next = count_reg + LEN_WIDTH'(1);
          state_next = WR_GAP;
        end
`ifdef WISHBONE_COPY_TIMEOUT_EN
        else if (tmo_hit) begin
          abort = 1'b1;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
`endif
      end

      // The counter was already advanced on the write ack. It therefore names
      // the next word, and it equals len once the last word is written.
      WR_GAP: begin
        if (count_reg == len_reg) begin
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          state_next = RD_REQ;
          stb_next   = 1'b1;
          we_next    = 1'b0;
          adr_next   = src_reg + ADDRESS_WIDTH'(count_reg);
        end
      end

      DONE: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end

      default: begin
        state_next = IDLE;
        stb_next   = 1'b0;
        we_next    = 1'b0;
        busy_next  = 1'b0;
      end
    endcase

`ifdef WISHBONE_COPY_TIMEOUT_EN
    // Abandon the copy. The remaining words are skipped and completion is
    // still signalled through DONE.
    if (abort) begin
      stb_next   = 1'b0;
      we_next    = 1'b0;
      busy_next  = 1'b0;
      err_next   = 1'b1;
      done_next  = 1'b1;
      state_next = DONE;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Output ports
  // ---------------------------------------------------------------------------
  assign busy_o = busy_reg;
  assign done_o = done_reg;
  assign adr_o  = adr_reg;
  assign dat_o  = dat_reg;
  assign we_o   = we_reg;
  assign stb_o  = stb_reg;
  assign cyc_o  = stb_reg;
  assign cti_o  = 3'b000;

`ifdef WISHBONE_COPY_TIMEOUT_EN
  assign err_o  = err_reg;
`else
  assign err_o  = 1'b0;
`endif

  // Every byte lane is selected exactly while the strobe is up.
  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_sel
    assign sel_o[gi] = stb_reg;
  end

endmodule

// File: doc/wishbone_copy_master.md
Name: wishbone_copy_master

Overview:
- Wishbone classic-cycle initiator that copies a block of words from a source address range to a destination address range, one word at a time.
- Sits between a control source (CPU register block or sequencer) and the shared Wishbone bus, in front of wishbone_memory and other word-addressed responders.
- Performs read-then-write per word, with a mandatory idle gap after every ack so registered-ack responders are never double-acked.

Parameters:
- ADDRESS_WIDTH, 16, width of the Wishbone address and of src/dst inputs; one address = one word.
- DATA_WIDTH, 8, Wishbone data width and internal holding-register width.
- DATA_BYTES, 1, width of sel_o.
- LEN_WIDTH, 16, width of the transfer-length input (words).
- TIMEOUT_CYCLES, 15, maximum cycles stb_o may wait for ack_i; used only with the optional feature.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle request; sampled only in IDLE.
- src_adr_i  in  ADDRESS_WIDTH  first source word address, latched on accepted start.
- dst_adr_i  in  ADDRESS_WIDTH  first destination word address, latched on accepted start.
- len_i  in  LEN_WIDTH  number of words to copy, latched on accepted start.
- busy_o  out  1  high while a copy is in progress.
- done_o  out  1  one-cycle pulse at completion (normal, zero-length or error).
- err_o  out  1  sticky error flag; cleared on next accepted start.
- adr_o  out  ADDRESS_WIDTH  Wishbone address.
- dat_o  out  DATA_WIDTH  Wishbone write data.
- dat_i  in  DATA_WIDTH  Wishbone read data.
- we_o  out  1  Wishbone write enable.
- sel_o  out  DATA_BYTES  byte selects; all ones whenever stb_o is high, else 0.
- stb_o  out  1  Wishbone strobe.
- cyc_o  out  1  Wishbone cycle; always equal to stb_o.
- ack_i  in  1  Wishbone acknowledge.
- cti_o  out  3  cycle type; constant 3'b000 (classic).

Behaviour:
- All outputs registered.
- Reset values: busy_o, done_o, err_o, stb_o, cyc_o, we_o = 0; adr_o, dat_o, sel_o = 0.
- Reset asserted mid-copy drops cyc_o/stb_o immediately and returns to IDLE with no done pulse.
- States: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, DONE.
- IDLE:
  - start_i=1 latches src, dst and len, clears err_o, and zeroes the word counter.
  - If len=0, go to DONE. Otherwise go to RD_REQ and raise busy_o.
  - start_i while not IDLE is ignored; the latched values are unchanged.
- RD_REQ:
  - Drives adr_o=src+count, we_o=0, cyc_o=stb_o=1.
  - On ack_i=1, capture dat_i into the holding register, drop cyc_o/stb_o, and go to RD_GAP.
- RD_GAP:
  - Exactly one cycle with cyc_o/stb_o low; ack_i is ignored (a stale registered ack is expected here).
  - Next state: WR_REQ.
- WR_REQ:
  - Drives adr_o=dst+count, dat_o=holding register, we_o=1, cyc_o=stb_o=1.
  - On ack_i=1, drop the strobes, increment the counter, and go to WR_GAP.
- WR_GAP:
  - One idle cycle.
  - If count==len, go to DONE; else go to RD_REQ.
- DONE:
  - done_o=1 and busy_o=0 for one cycle, then IDLE.
- ack_i is ignored whenever stb_o=0.
- Address arithmetic is modulo 2^ADDRESS_WIDTH; ranges wrap at the top of the address space.
- No overlap detection: the copy is always ascending.
- Timing with a zero-wait, registered-ack responder:
  - 6 cycles per word.
  - start accepted at edge 0 gives busy_o high in cycles 1..6N and done_o in cycle 6N+1.
  - len=0 gives done_o in cycle 1 and no bus activity.

Optional Feature:
- Macro: WISHBONE_COPY_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while in RD_REQ or WR_REQ and resets on entry to each REQ state.
  - If TIMEOUT_CYCLES cycles elapse without ack_i: drop cyc_o/stb_o, set err_o=1, and go to DONE (done_o pulses).
  - Remaining words are not transferred.
- Without the macro:
  - No counter; the block waits indefinitely for ack_i.
  - err_o is tied 0.

Test Plan:
- 4-word copy: memory[0x010..0x013]=A1,B2,C3,D4; start src=0x010 dst=0x100 len=4 -> memory[0x100..0x103]=A1,B2,C3,D4; done_o in cycle 25; err_o=0; exactly 8 acked accesses.
- Zero length: start len=0 -> done_o in cycle 1; cyc_o never asserted; busy_o stays 0.
- Start while busy: second start (src=0x020) in cycle 5 of a len=2 copy -> ignored; only the original destination words are written; single done_o.
- Reset mid-copy: rst_ni low during WR_REQ of word 2 of a len=4 copy -> cyc_o=0 immediately; busy_o=0; destination word 2 onward unwritten; no done_o.
- Wrap: src=0xFFFE dst=0x0040 len=3 -> reads at 0xFFFE, 0xFFFF, 0x0000 in that order; writes 0x0040..0x0042.
- Timeout (macro on, TIMEOUT_CYCLES=15): src=0x0300 against a 512-word memory (no ack) -> cyc_o drops after 15 cycles; err_o=1; done_o pulses; no write issued. Next valid start clears err_o.
